// File: rtl/pd2_pwr_pkg.sv
// PD2 power-switch sequencer: shared state encoding, default parameters
// and a small compile-time helper.
package pd2_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'b000,
        ST_RAMP_UP   = 3'b001,
        ST_SW_WAIT   = 3'b010,
        ST_SETTLE    = 3'b011,
        ST_ON        = 3'b100,
        ST_DRAIN     = 3'b101,
        ST_SLEEP_ACK = 3'b110,
        ST_RAMP_DN   = 3'b111
    } seq_state_t;

    localparam int DEF_NUM_SW_STAGES = 4;
    localparam int DEF_STAGE_DLY     = 8;
    localparam int DEF_SETTLE_DLY    = 16;
    localparam int DEF_IDLE_CYCLES   = 4;
    localparam int DEF_TIMEOUT_CYC   = 255;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwr_dly_cnt.sv
// Saturating up-counter with clear, load and enable. done_o is high once
// the count has reached the limit presented on lim_i.
module pwr_dly_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    input  logic [W-1:0] lim_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear beats load beats increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (ld_i)
            cnt_d = ld_val_i;
        else if (en_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q >= lim_i);

endmodule

// File: rtl/pd2_pwr_switch_seq.sv
// PD2 power-switch sequencer. Ramps the switch chain up one segment at a
// time, waits for the chain ack and a settle time, then acks power-on.
// On a sleep request it drains bus activity, acks sleep, and ramps down in
// reverse order once power-on is withdrawn.
// Optional: define PD2_SW_TIMEOUT_EN to abort a ramp whose switch ack never
// arrives (sticky o_sw_err, falls through to ramp-down).
module pd2_pwr_switch_seq
    import pd2_pwr_pkg::*;
#(
    parameter int NUM_SW_STAGES = DEF_NUM_SW_STAGES,
    parameter int STAGE_DLY     = DEF_STAGE_DLY,
    parameter int SETTLE_DLY    = DEF_SETTLE_DLY,
    parameter int IDLE_CYCLES   = DEF_IDLE_CYCLES,
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic                     i_aon_clk,
    input  logic                     i_soc_pwr_on_rst,
    input  logic                     i_pwr_on_req,
    input  logic                     i_hw_sleep_req,
    input  logic                     i_pd2_busy,
    input  logic                     i_sw_ack,
    output logic                     o_pwr_on_ack,
    output logic                     o_hw_sleep_ack,
    output logic [NUM_SW_STAGES-1:0] o_sw_en,
    output logic                     o_sw_err,
    output logic [2:0]               o_seq_state
);

    localparam int MAX_DLY = max2(max2(STAGE_DLY, SETTLE_DLY), max2(IDLE_CYCLES, TIMEOUT_CYC));
    localparam int CNT_W   = $clog2(MAX_DLY + 1);

    // Limits are N-1: the exit decision is taken in the N-th cycle so the
    // new state shows up exactly N cycles after entry.
    localparam logic [CNT_W-1:0] STAGE_LIM  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_DLY - 1);
    localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
`ifdef PD2_SW_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT_CYC - 1);
`endif
    localparam logic [NUM_SW_STAGES-1:0] SW_LSB = NUM_SW_STAGES'(1);

    seq_state_t                 state_q, state_d;
    logic                       armed_q, armed_d;
    logic [NUM_SW_STAGES-1:0]   sw_en_q, sw_en_d;
    logic                       pwr_on_ack_q, pwr_on_ack_d;
    logic                       sleep_ack_q, sleep_ack_d;

    logic                       cnt_clr, cnt_en, cnt_done, step;
    logic [CNT_W-1:0]           cnt_lim;

    // One timer serves every timed state; it restarts on each state change,
    // on each ramp step, and whenever PD2 reports busy while draining.
    always_comb begin
        cnt_lim = STAGE_LIM;
        case (state_q)
            ST_SETTLE:  cnt_lim = SETTLE_LIM;
            ST_DRAIN:   cnt_lim = IDLE_LIM;
`ifdef PD2_SW_TIMEOUT_EN
            ST_SW_WAIT: cnt_lim = TMO_LIM;
`endif
            default: ;
        endcase
        step    = ((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DN)) && cnt_done;
        cnt_en  = (state_q != ST_OFF) && (state_q != ST_ON) && (state_q != ST_SLEEP_ACK);
        cnt_clr = (state_d != state_q) || step || ((state_q == ST_DRAIN) && i_pd2_busy);
    end

    pwr_dly_cnt #(.W(CNT_W)) u_tmr (
        .clk_i    (i_aon_clk),
        .rst_i    (i_soc_pwr_on_rst),
        .clr_i    (cnt_clr),
        .ld_i     (1'b0),
        .ld_val_i ({CNT_W{1'b0}}),
        .en_i     (cnt_en),
        .lim_i    (cnt_lim),
        .done_o   (cnt_done)
    );

    // Next state and armed flag; each state tests only its own exit.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            ST_OFF:       if (i_pwr_on_req) state_d = ST_RAMP_UP;
            ST_RAMP_UP:   if (cnt_done && sw_en_q[NUM_SW_STAGES-1]) state_d = ST_SW_WAIT;
            ST_SW_WAIT: begin
                if (i_sw_ack)
                    state_d = ST_SETTLE;
`ifdef PD2_SW_TIMEOUT_EN
                else if (cnt_done)
                    state_d = ST_RAMP_DN;
`endif
            end
            ST_SETTLE: begin
                if (cnt_done) begin
                    state_d = ST_ON;
                    armed_d = 1'b0;
                end
            end
            ST_ON: begin
                // The FSM still holds sleep high while waiting for power-on
                // ack; only a request seen after a low cycle counts.
                if (!i_hw_sleep_req)
                    armed_d = 1'b1;
                else if (armed_q)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i_hw_sleep_req)
                    state_d = ST_ON;
                else if (!i_pd2_busy && cnt_done)
                    state_d = ST_SLEEP_ACK;
            end
            ST_SLEEP_ACK: if (!i_pwr_on_req) state_d = ST_RAMP_DN;
            ST_RAMP_DN:   if ((sw_en_q == '0) && !i_sw_ack) state_d = ST_OFF;
            default:      state_d = ST_OFF;
        endcase
    end

    // Registered outputs: switch enables step with the timer, acks follow the next state.
    always_comb begin
        sw_en_d = sw_en_q;
        case (state_q)
            ST_OFF:     if (state_d == ST_RAMP_UP) sw_en_d = SW_LSB;
            ST_RAMP_UP: if (step && !sw_en_q[NUM_SW_STAGES-1]) sw_en_d = (sw_en_q << 1) | SW_LSB;
            ST_RAMP_DN: if (step) sw_en_d = sw_en_q >> 1;
            default:    if (state_d == ST_RAMP_DN) sw_en_d = sw_en_q >> 1;
        endcase
        pwr_on_ack_d = (state_d == ST_ON) || (state_d == ST_DRAIN) || (state_d == ST_SLEEP_ACK);
        sleep_ack_d  = !((state_d == ST_ON) || (state_d == ST_DRAIN));
    end

    // State and output registers; reset opens every switch on the next edge.
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            state_q      <= ST_OFF;
            armed_q      <= 1'b0;
            sw_en_q      <= '0;
            pwr_on_ack_q <= 1'b0;
            sleep_ack_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            sw_en_q      <= sw_en_d;
            pwr_on_ack_q <= pwr_on_ack_d;
            sleep_ack_q  <= sleep_ack_d;
        end
    end

`ifdef PD2_SW_TIMEOUT_EN
    logic err_q;

    // Sticky timeout flag, set when SW_WAIT gives up.
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst)
            err_q <= 1'b0;
        else if ((state_q == ST_SW_WAIT) && (state_d == ST_RAMP_DN))
            err_q <= 1'b1;
    end

    assign o_sw_err = err_q;
`else
    assign o_sw_err = 1'b0;
`endif

    assign o_pwr_on_ack   = pwr_on_ack_q;
    assign o_hw_sleep_ack = sleep_ack_q;
    assign o_sw_en        = sw_en_q;
    assign o_seq_state    = state_q;

endmodule

// File: tb/tb_pd2_pwr_switch_seq.sv
// Bench for pd2_pwr_switch_seq: table of timed vectors plus a hand-written
// reset sequence; expected snapshots go through a cycle-stamped scoreboard.
module tb_pd2_pwr_switch_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0, slp = 1'b0, busy = 1'b0, ack = 1'b0;
    logic       pa, sa, err;
    logic [3:0] en;
    logic [2:0] st;

    always #5 clk = ~clk;

    pd2_pwr_switch_seq dut (
        .i_aon_clk        (clk),
        .i_soc_pwr_on_rst (rst),
        .i_pwr_on_req     (req),
        .i_hw_sleep_req   (slp),
        .i_pd2_busy       (busy),
        .i_sw_ack         (ack),
        .o_pwr_on_ack     (pa),
        .o_hw_sleep_ack   (sa),
        .o_sw_en          (en),
        .o_sw_err         (err),
        .o_seq_state      (st)
    );

    localparam logic [2:0] OFF = 3'd0, RU = 3'd1, SW = 3'd2, SE = 3'd3,
                           ON  = 3'd4, DR = 3'd5, SA = 3'd6, RD = 3'd7;

    // in = {req, sleep_req, busy, sw_ack}, applied after the check at cyc
    typedef struct {
        int         cyc;
        logic [3:0] in;
        logic [2:0] st;
        logic [3:0] en;
        logic       pa, sa, err;
    } vec_t;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] st;
        logic [3:0] en;
        logic       pa, sa, err;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;

    function automatic vec_t mk(int c, logic [3:0] in, logic [2:0] s, logic [3:0] e,
                                logic p, logic a, logic r);
        vec_t v;
        v.cyc = c; v.in = in; v.st = s; v.en = e; v.pa = p; v.sa = a; v.err = r;
        return v;
    endfunction

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || {st, en, pa, sa, err} !== {e.st, e.en, e.pa, e.sa, e.err}) begin
                errors++;
                $display("FAIL %s @%0d: got st=%0d en=%b pa=%b sa=%b err=%b, want st=%0d en=%b pa=%b sa=%b err=%b (due %0d)",
                         e.tag, cyc, st, en, pa, sa, err, e.st, e.en, e.pa, e.sa, e.err, e.cyc);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic expect_now(string tag, logic [2:0] s, logic [3:0] e, logic p, logic a, logic r);
        exp_t x;
        x.cyc = cyc; x.tag = tag; x.st = s; x.en = e; x.pa = p; x.sa = a; x.err = r;
        sb.push_back(x);
        check_due();
    endtask

    task automatic run_vq(string tag);
        exp_t x;
        int   b;
        b = cyc;
        foreach (vq[i]) begin
            x.cyc = b + vq[i].cyc;
            x.tag = $sformatf("%s[%0d]", tag, vq[i].cyc);
            x.st = vq[i].st; x.en = vq[i].en; x.pa = vq[i].pa; x.sa = vq[i].sa; x.err = vq[i].err;
            sb.push_back(x);
            check_due();
            while (cyc < x.cyc) step();
            {req, slp, busy, ack} = vq[i].in;
        end
        vq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        rst = 1'b0;

        // power-up, drain, ramp-down with early re-request, second power-up
        vq.push_back(mk(  0, 4'b1100, OFF, 4'b0000, 0, 1, 0));
        vq.push_back(mk(  1, 4'b1100, RU,  4'b0001, 0, 1, 0));
        vq.push_back(mk(  8, 4'b1100, RU,  4'b0001, 0, 1, 0));
        vq.push_back(mk(  9, 4'b1100, RU,  4'b0011, 0, 1, 0));
        vq.push_back(mk( 17, 4'b1100, RU,  4'b0111, 0, 1, 0));
        vq.push_back(mk( 25, 4'b1100, RU,  4'b1111, 0, 1, 0));
        vq.push_back(mk( 32, 4'b1100, RU,  4'b1111, 0, 1, 0));
        vq.push_back(mk( 33, 4'b1100, SW,  4'b1111, 0, 1, 0));
        vq.push_back(mk( 40, 4'b1101, SW,  4'b1111, 0, 1, 0));
        vq.push_back(mk( 41, 4'b1101, SE,  4'b1111, 0, 1, 0));
        vq.push_back(mk( 56, 4'b1101, SE,  4'b1111, 0, 1, 0));
        vq.push_back(mk( 57, 4'b1101, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk( 70, 4'b1001, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk( 71, 4'b1101, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk( 72, 4'b1101, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk( 75, 4'b1101, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk( 76, 4'b1101, SA,  4'b1111, 1, 1, 0));
        vq.push_back(mk( 80, 4'b0101, SA,  4'b1111, 1, 1, 0));
        vq.push_back(mk( 81, 4'b0101, RD,  4'b0111, 0, 1, 0));
        vq.push_back(mk( 88, 4'b0101, RD,  4'b0111, 0, 1, 0));
        vq.push_back(mk( 89, 4'b1101, RD,  4'b0011, 0, 1, 0));
        vq.push_back(mk( 97, 4'b1101, RD,  4'b0001, 0, 1, 0));
        vq.push_back(mk(104, 4'b1101, RD,  4'b0001, 0, 1, 0));
        vq.push_back(mk(105, 4'b1100, RD,  4'b0000, 0, 1, 0));
        vq.push_back(mk(106, 4'b1100, OFF, 4'b0000, 0, 1, 0));
        vq.push_back(mk(107, 4'b1100, RU,  4'b0001, 0, 1, 0));
        vq.push_back(mk(138, 4'b1100, RU,  4'b1111, 0, 1, 0));
        vq.push_back(mk(139, 4'b1101, SW,  4'b1111, 0, 1, 0));
        vq.push_back(mk(140, 4'b1101, SE,  4'b1111, 0, 1, 0));
        vq.push_back(mk(155, 4'b1101, SE,  4'b1111, 0, 1, 0));
        vq.push_back(mk(156, 4'b1101, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk(160, 4'b1001, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk(161, 4'b1101, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk(162, 4'b1101, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk(163, 4'b1001, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk(164, 4'b1101, ON,  4'b1111, 1, 0, 0));
        vq.push_back(mk(165, 4'b1101, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk(168, 4'b1111, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk(169, 4'b1101, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk(172, 4'b1101, DR,  4'b1111, 1, 0, 0));
        vq.push_back(mk(173, 4'b1101, SA,  4'b1111, 1, 1, 0));
        run_vq("pwr");

        // reset while fully powered, then reset while settling
        rst = 1'b1;
        step();
        expect_now("rst_sleep_ack", OFF, 4'b0000, 0, 1, 0);
        rst = 1'b0; req = 1'b1; slp = 1'b1; busy = 1'b0; ack = 1'b1;
        repeat (34) step();
        expect_now("settle_entry", SE, 4'b1111, 0, 1, 0);
        repeat (6) step();
        expect_now("settle_mid", SE, 4'b1111, 0, 1, 0);
        rst = 1'b1;
        step();
        expect_now("rst_settle", OFF, 4'b0000, 0, 1, 0);
        rst = 1'b0; req = 1'b0; ack = 1'b0;
        repeat (2) step();
        expect_now("off_idle", OFF, 4'b0000, 0, 1, 0);

`ifdef PD2_SW_TIMEOUT_EN
        // switch ack never arrives
        vq.push_back(mk(  0, 4'b1000, OFF, 4'b0000, 0, 1, 0));
        vq.push_back(mk( 33, 4'b1000, SW,  4'b1111, 0, 1, 0));
        vq.push_back(mk(287, 4'b1000, SW,  4'b1111, 0, 1, 0));
        vq.push_back(mk(288, 4'b0000, RD,  4'b0111, 0, 1, 1));
        vq.push_back(mk(312, 4'b0000, RD,  4'b0000, 0, 1, 1));
        vq.push_back(mk(313, 4'b0000, OFF, 4'b0000, 0, 1, 1));
        vq.push_back(mk(320, 4'b0000, OFF, 4'b0000, 0, 1, 1));
        run_vq("tmo");
        rst = 1'b1;
        step();
        expect_now("tmo_rst", OFF, 4'b0000, 0, 1, 0);
        rst = 1'b0;
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pd2_pwr_switch_seq.md
Name: pd2_pwr_switch_seq

Overview:
- PD2-side power-switch sequencer; sits directly downstream of the PD2 power-controller FSM.
- Consumes the FSM's power-on request and hardware sleep request. Produces its power-on and sleep acknowledges.
- Drives the PD2 power-switch enable chain in staged order to limit inrush current.
- Drains PD2 bus activity before granting sleep; ramps the switches down in reverse order once power-off is confirmed.

Parameters:
- NUM_SW_STAGES, 4: number of power-switch segments, enabled one at a time.
- STAGE_DLY, 8: cycles between consecutive stage enables/disables; must be ≥1.
- SETTLE_DLY, 16: cycles after i_sw_ack before o_pwr_on_ack asserts; must be ≥1.
- IDLE_CYCLES, 4: consecutive cycles of ~i_pd2_busy required before the sleep ack.
- TIMEOUT_CYC, 255: switch-ack timeout in cycles; used only with PD2_SW_TIMEOUT_EN.

Ports:
- i_aon_clk  in  1  always-on clock; the only clock.
- i_soc_pwr_on_rst  in  1  reset, synchronous, active-high.
- i_pwr_on_req  in  1  power-on request from the PD2 FSM.
- i_hw_sleep_req  in  1  hardware sleep request from the PD2 FSM.
- i_pd2_busy  in  1  PD2 has outstanding bus transactions.
- i_sw_ack  in  1  last-segment ack of the power-switch daisy chain.
- o_pwr_on_ack  out  1  PD2 powered and settled.
- o_hw_sleep_ack  out  1  PD2 quiesced or off.
- o_sw_en  out  NUM_SW_STAGES  power-switch segment enables.
- o_sw_err  out  1  sticky switch-ack timeout flag.
- o_seq_state  out  3  current state, for debug.

Behaviour:
- Clock and reset: one clock, i_aon_clk. Reset i_soc_pwr_on_rst is synchronous and active-high.
- Reset values: state OFF, o_sw_en=0, o_pwr_on_ack=0, o_hw_sleep_ack=1, o_sw_err=0, all counters 0, armed flag 0. A reset mid-operation opens all switches on the next edge.
- All outputs are registered and derived from the state.
  - o_pwr_on_ack=1 in ON, DRAIN and SLEEP_ACK.
  - o_hw_sleep_ack=1 in OFF, RAMP_UP, SW_WAIT, SETTLE, SLEEP_ACK and RAMP_DN; it is 0 only in ON and DRAIN.
- OFF (000): if i_pwr_on_req=1, go to RAMP_UP and set o_sw_en[0] on the same edge.
- RAMP_UP (001):
  - Sets o_sw_en[k] exactly k*STAGE_DLY cycles after o_sw_en[0]; bits are set in ascending order and are never cleared here.
  - Leaves for SW_WAIT NUM_SW_STAGES*STAGE_DLY cycles after entry.
  - i_pwr_on_req falling here is ignored; the ramp always completes.
- SW_WAIT (010): when i_sw_ack=1, go to SETTLE.
- SETTLE (011): count SETTLE_DLY cycles, then go to ON. The armed flag is cleared on entry to ON.
- ON (100):
  - The armed flag sets on the first cycle with i_hw_sleep_req=0. This is needed because the FSM still holds the sleep request high while it waits for the power-on ack.
  - If armed and i_hw_sleep_req=1, go to DRAIN.
- DRAIN (101):
  - The idle counter increments while i_pd2_busy=0 and clears to 0 when i_pd2_busy=1.
  - When the counter reaches IDLE_CYCLES, go to SLEEP_ACK.
  - If i_hw_sleep_req drops, return to ON with armed still set.
- SLEEP_ACK (110): hold both acks high. When i_pwr_on_req=0, go to RAMP_DN and drop o_pwr_on_ack on the same edge.
- RAMP_DN (111):
  - Clears o_sw_en from the top bit down, one bit per STAGE_DLY cycles; the top bit clears on entry.
  - When o_sw_en==0 and i_sw_ack==0, go to OFF.
  - A new i_pwr_on_req during RAMP_DN is honoured only after reaching OFF; it is never a direct re-ramp.
- Simultaneous events: state priority is fixed by the state encoding, since each state tests only its own exit condition. There are no other cross-state shortcuts.
- Counter width: $clog2 of (max of all delay parameters)+1. Counters saturate and never wrap.

Optional Feature:
- Macro: PD2_SW_TIMEOUT_EN.
- Defined: SW_WAIT counts cycles. If i_sw_ack is still 0 after TIMEOUT_CYC cycles, go to RAMP_DN and set o_sw_err. o_sw_err is sticky until reset; o_pwr_on_ack never asserts on that attempt.
- Undefined: SW_WAIT waits indefinitely, and o_sw_err is tied to 0.

Decomposition:
- Package pd2_pwr_pkg holds the seq_state_t enum (3-bit encodings as listed above) and the default parameter constants.
- One sub-module, pwr_dly_cnt: a parameterised saturating counter with load/clear/enable and a done flag. It is shared by the stage, settle, idle and timeout timing.

Test Plan:
- Power-up with defaults, i_pwr_on_req at cycle 0, i_sw_ack raised at cycle 40 → o_sw_en is 0001/0011/0111/1111 at cycles 1/9/17/25; state SW_WAIT at cycle 33; o_pwr_on_ack=1 and o_hw_sleep_ack=0 at cycle 57.
- In ON with i_hw_sleep_req held at 1 from the FSM and never dropping → the block stays in ON with no sleep ack. Then drop the request for 1 cycle, re-raise it, and hold i_pd2_busy=0 → o_hw_sleep_ack=1 exactly 4 cycles after DRAIN entry.
- In DRAIN, pulse i_pd2_busy at idle count 3 → the count restarts, and the ack is delayed by 4 cycles after busy falls.
- SLEEP_ACK, then drop i_pwr_on_req → o_pwr_on_ack=0 next edge; o_sw_en is 0111/0011/0001/0000 at 8-cycle spacing; OFF once i_sw_ack=0. Re-raise i_pwr_on_req during RAMP_DN → the re-ramp starts only after OFF.
- Assert reset in SETTLE → next edge: o_sw_en=0, o_pwr_on_ack=0, o_hw_sleep_ack=1, state OFF.
- PD2_SW_TIMEOUT_EN defined, i_sw_ack held at 0 → RAMP_DN after 255 SW_WAIT cycles; o_sw_err=1 and it stays 1 through OFF until reset.
